alarm_ctrl: RTL and testbench

//  Alarm sequencer between the debounced-button/timekeeping front end and SongPlayer.

---
 rtl/alarm_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//
// Alarm sequencer that sits between the debounced-button / timekeeping front
// end and the song player. It holds a BCD alarm time (HH:MM), edited by the
// inc_hr / inc_min button ticks, and compares it with the current time. When
// the two match it raises play_sound to start the song. While the alarm rings
// the user can snooze or stop it, and ringing ends by itself after RING_SECS
// seconds.
//
// Parameters
//   RING_SECS    sec_ticks spent in RINGING before auto-stop        (1..255)
//   SNOOZE_SECS  sec_ticks spent in SNOOZE before ringing again      (1..65535)
//   MAX_SNOOZE   snoozes allowed per alarm event                     (0..3)
//                (exists only when SNOOZE_LIMIT_EN is defined)
//
// Build option
//   SNOOZE_LIMIT_EN  when defined, at most MAX_SNOOZE snoozes are allowed
//                    per alarm event. A further snooze_tick acts as stop.
//                    When undefined, snooze is unlimited.
//
// Ports
//   clk           in   1  system clock (100 MHz)
//   reset         in   1  synchronous, active-low reset
//   sec_tick      in   1  one-cycle pulse, once per second
//   cur_hh        in   8  current hour,   BCD 00..23
//   cur_mm        in   8  current minute, BCD 00..59
//   cur_ss        in   8  current second, BCD 00..59
//   alarm_on      in   1  arm switch (level)
//   inc_hr_tick   in   1  one-cycle pulse, alarm hour +1
//   inc_min_tick  in   1  one-cycle pulse, alarm minute +1
//   snooze_tick   in   1  one-cycle pulse, snooze
//   stop_tick     in   1  one-cycle pulse, stop ringing
//   alarm_hh      out  8  alarm hour,   BCD (to the 7-segment mux)
//   alarm_mm      out  8  alarm minute, BCD (to the 7-segment mux)
//   play_sound    out  1  high while RINGING
//   state         out  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
//
// All outputs are registered. Every response appears on the clock edge after
// the input that causes it.
// -----------------------------------------------------------------------------
module alarm_ctrl #(
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300
`ifdef SNOOZE_LIMIT_EN
   ,
   parameter int unsigned MAX_SNOOZE  = 3
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_tick,
   input  logic [7:0] cur_hh,
   input  logic [7:0] cur_mm,
   input  logic [7:0] cur_ss,
   input  logic       alarm_on,
   input  logic       inc_hr_tick,
   input  logic       inc_min_tick,
   input  logic       snooze_tick,
   input  logic       stop_tick,
   output logic [7:0] alarm_hh,
   output logic [7:0] alarm_mm,
   output logic       play_sound,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ARMED   = 2'b01,
      S_RINGING = 2'b10,
      S_SNOOZE  = 2'b11
   } state_e;

   localparam logic [7:0]  RING_LAST   = 8'(RING_SECS - 1);
   localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SECS);

   // BCD increment with wrap: 'top' wraps to 00, and a ones digit of 9 rolls
   // to 0 with a carry into the tens digit. No carry leaves the field.
   function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                          input logic [7:0] top);
      logic [7:0] res;
      if (val == top) begin
         res = 8'h00;
      end else if (val[3:0] == 4'd9) begin
         res = {val[7:4] + 4'd1, 4'd0};
      end else begin
         res = {val[7:4], val[3:0] + 4'd1};
      end
      return res;
   endfunction

   state_e      state_q;
   logic [7:0]  alarm_hh_q, alarm_hh_d;
   logic [7:0]  alarm_mm_q, alarm_mm_d;
   logic [7:0]  ring_cnt_q;
   logic [15:0] snz_cnt_q;
   logic        play_sound_q;
   logic        match_q;          // match from the previous cycle
   logic        match;
   logic        trigger;
   logic        edit_en;
   logic        snooze_exhausted; // snooze_tick must behave as stop

   // ---------------------------------------------------------------------------
   // Time compare and alarm-time editing
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default at the top of the block, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      match      = (cur_hh == alarm_hh_q) && (cur_mm == alarm_mm_q) && (cur_ss == 8'h00);
      // Rising edge of match: fires once per matching minute, not on every
      // cycle of second 00.
      trigger    = match && !match_q;
      edit_en    = (state_q == S_IDLE) || (state_q == S_ARMED);
      alarm_hh_d = alarm_hh_q;
      alarm_mm_d = alarm_mm_q;
      if (edit_en && inc_hr_tick) begin
         alarm_hh_d = bcd_inc(alarm_hh_q, 8'h23);
      end
      if (edit_en && inc_min_tick) begin
         alarm_mm_d = bcd_inc(alarm_mm_q, 8'h59);
      end
   end

`ifdef SNOOZE_LIMIT_EN
   logic [1:0] snz_used_q;
   assign snooze_exhausted = (snz_used_q == 2'(MAX_SNOOZE));
`else
   assign snooze_exhausted = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Alarm FSM with its counters and registered outputs
   // Priority in RINGING / SNOOZE: disarm > stop > snooze > timer expiry.
   // ---------------------------------------------------------------------------
   // NOTE: all state here is assigned with non-blocking (<=) so every register
   // samples the pre-edge value of every other register, independent of
   // statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         alarm_hh_q   <= 8'h06;
         alarm_mm_q   <= 8'h00;
         ring_cnt_q   <= 8'd0;
         snz_cnt_q    <= 16'd0;
         play_sound_q <= 1'b0;
         match_q      <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
         snz_used_q   <= 2'd0;
`endif
      end else begin
         match_q    <= match;
         alarm_hh_q <= alarm_hh_d;
         alarm_mm_q <= alarm_mm_d;

         case (state_q)
            S_IDLE: begin
               if (alarm_on) begin
                  state_q <= S_ARMED;
               end
            end

            S_ARMED: begin
               if (!alarm_on) begin
                  state_q <= S_IDLE;
               end else if (trigger) begin
                  state_q      <= S_RINGING;
                  ring_cnt_q   <= 8'd0;
                  play_sound_q <= 1'b1;
`ifdef SNOOZE_LIMIT_EN
                  // A fresh alarm event gets the full snooze allowance.
                  snz_used_q   <= 2'd0;
`endif
               end
            end

            S_RINGING: begin
               if (!alarm_on) begin
                  state_q      <= S_IDLE;
                  play_sound_q <= 1'b0;
               end else if (stop_tick || (snooze_tick && snooze_exhausted)) begin
                  state_q      <= S_ARMED;
                  play_sound_q <= 1'b0;
               end else if (snooze_tick) begin
                  state_q      <= S_SNOOZE;
                  snz_cnt_q    <= SNOOZE_LOAD;
                  play_sound_q <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
                  snz_used_q   <= snz_used_q + 2'd1;
`endif
               end else if (sec_tick) begin
                  if (ring_cnt_q == RING_LAST) begin
                     state_q      <= S_ARMED;
                     play_sound_q <= 1'b0;
                  end else begin
                     ring_cnt_q <= ring_cnt_q + 8'd1;
                  end
               end
            end

            S_SNOOZE: begin
               if (!alarm_on) begin
                  state_q <= S_IDLE;
               end else if (stop_tick) begin
                  state_q <= S_ARMED;
               end else if (sec_tick) begin
                  if (snz_cnt_q == 16'd1) begin
                     state_q      <= S_RINGING;
                     ring_cnt_q   <= 8'd0;
                     play_sound_q <= 1'b1;
                  end else begin
                     snz_cnt_q <= snz_cnt_q - 16'd1;
                  end
               end
            end

            default: begin
               state_q      <= S_IDLE;
               play_sound_q <= 1'b0;
            end
         endcase
      end
   end

   assign alarm_hh   = alarm_hh_q;
   assign alarm_mm   = alarm_mm_q;
   assign play_sound = play_sound_q;
   assign state      = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
//
// Bench for alarm_ctrl with short timers (RING_SECS=4, SNOOZE_SECS=3,
// MAX_SNOOZE=2 when SNOOZE_LIMIT_EN is defined). The reference model keeps the
// alarm time and current time as plain integers and counts elapsed/remaining
// seconds directly. A directed vector table, hand-written corner-case
// sequences and a randomized run are all compared against it.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;

   localparam int RING   = 4;
   localparam int SNZ    = 3;
   localparam int MAXS   = 2;
`ifdef SNOOZE_LIMIT_EN
   localparam bit LIMIT  = 1'b1;
`else
   localparam bit LIMIT  = 1'b0;
`endif

   localparam int IDLE = 0, ARMED = 1, RINGING = 2, SNOOZE = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       sec_tick;
   logic [7:0] cur_hh, cur_mm, cur_ss;
   logic       alarm_on, inc_hr_tick, inc_min_tick, snooze_tick, stop_tick;
   logic [7:0] alarm_hh, alarm_mm;
   logic       play_sound;
   logic [1:0] state;

   int cur_h, cur_m, cur_s;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int m_state, m_h, m_m, m_ring, m_snz, m_used;
   bit m_prev;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   assign cur_hh = to_bcd(cur_h);
   assign cur_mm = to_bcd(cur_m);
   assign cur_ss = to_bcd(cur_s);

   always #5 clk = ~clk;

   alarm_ctrl #(
      .RING_SECS  (RING),
      .SNOOZE_SECS(SNZ)
`ifdef SNOOZE_LIMIT_EN
      ,
      .MAX_SNOOZE (MAXS)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sec_tick    (sec_tick),
      .cur_hh      (cur_hh),
      .cur_mm      (cur_mm),
      .cur_ss      (cur_ss),
      .alarm_on    (alarm_on),
      .inc_hr_tick (inc_hr_tick),
      .inc_min_tick(inc_min_tick),
      .snooze_tick (snooze_tick),
      .stop_tick   (stop_tick),
      .alarm_hh    (alarm_hh),
      .alarm_mm    (alarm_mm),
      .play_sound  (play_sound),
      .state       (state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: one call per clock edge, using the inputs as they are
   // presented to the DUT for that edge.
   task automatic model_step();
      bit match, trig, editable;
      match = (cur_h == m_h) && (cur_m == m_m) && (cur_s == 0);
      if (!reset) begin
         m_state = IDLE; m_h = 6; m_m = 0;
         m_ring = 0; m_snz = 0; m_used = 0; m_prev = 1'b0;
      end else begin
         trig     = match && !m_prev;
         m_prev   = match;
         editable = (m_state == IDLE) || (m_state == ARMED);
         if (editable && inc_hr_tick)  m_h = (m_h + 1) % 24;
         if (editable && inc_min_tick) m_m = (m_m + 1) % 60;
         case (m_state)
            IDLE:    if (alarm_on) m_state = ARMED;
            ARMED: begin
               if (!alarm_on) m_state = IDLE;
               else if (trig) begin m_state = RINGING; m_ring = 0; m_used = 0; end
            end
            RINGING: begin
               if (!alarm_on) m_state = IDLE;
               else if (stop_tick) m_state = ARMED;
               else if (snooze_tick) begin
                  if (LIMIT && m_used == MAXS) m_state = ARMED;
                  else begin m_state = SNOOZE; m_snz = SNZ; m_used++; end
               end else if (sec_tick) begin
                  m_ring++;
                  if (m_ring == RING) m_state = ARMED;
               end
            end
            default: begin // SNOOZE
               if (!alarm_on) m_state = IDLE;
               else if (stop_tick) m_state = ARMED;
               else if (sec_tick) begin
                  m_snz--;
                  if (m_snz == 0) begin m_state = RINGING; m_ring = 0; end
               end
            end
         endcase
      end
   endtask

   // Apply current inputs for one edge, compare with the model, clear pulses.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("m_state", 32'(state), 32'(m_state));
      check("m_play", 32'(play_sound), 32'(m_state == RINGING));
      check("m_hh", 32'(alarm_hh), 32'(to_bcd(m_h)));
      check("m_mm", 32'(alarm_mm), 32'(to_bcd(m_m)));
      inc_hr_tick = 0; inc_min_tick = 0; snooze_tick = 0; stop_tick = 0; sec_tick = 0;
   endtask

   task automatic expect_out(input string name, input logic [1:0] st, input logic ply);
      check({name, "_state"}, 32'(state), 32'(st));
      check({name, "_play"}, 32'(play_sound), 32'(ply));
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_h = h; cur_m = m; cur_s = s;
   endtask

   typedef struct {
      logic on, hr, mn, snz, stp, sec;
      int   ch, cm, cs;
      logic [1:0] st;
      logic       ply;
      logic [7:0] hh, mm;
   } vec_t;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12,0,30, 2'd0,1'b0, 8'h06,8'h00};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12,0,30, 2'd0,1'b0, 8'h07,8'h00};
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 12,0,30, 2'd0,1'b0, 8'h07,8'h01};
      vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 12,0,30, 2'd0,1'b0, 8'h08,8'h02};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 12,0,30, 2'd1,1'b0, 8'h08,8'h02};
      vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 12,0,30, 2'd1,1'b0, 8'h08,8'h03};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,  8,3, 0, 2'd2,1'b1, 8'h08,8'h03};
      vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,  8,3, 0, 2'd2,1'b1, 8'h08,8'h03};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,  8,3, 1, 2'd1,1'b0, 8'h08,8'h03};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,  8,3, 1, 2'd1,1'b0, 8'h08,8'h03};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,  8,3, 1, 2'd0,1'b0, 8'h08,8'h03};

      reset = 0; sec_tick = 0; alarm_on = 0;
      inc_hr_tick = 0; inc_min_tick = 0; snooze_tick = 0; stop_tick = 0;
      set_cur(12, 0, 30);

      // reset state
      step(); step();
      expect_out("reset", 2'd0, 1'b0);
      check("reset_hh", 32'(alarm_hh), 32'h06);
      check("reset_mm", 32'(alarm_mm), 32'h00);
      reset = 1;

      // directed vector table
      for (int i = 0; i < 11; i++) begin
         alarm_on = vecs[i].on; inc_hr_tick = vecs[i].hr; inc_min_tick = vecs[i].mn;
         snooze_tick = vecs[i].snz; stop_tick = vecs[i].stp; sec_tick = vecs[i].sec;
         set_cur(vecs[i].ch, vecs[i].cm, vecs[i].cs);
         step();
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d_play", i), 32'(play_sound), 32'(vecs[i].ply));
         check($sformatf("vec%0d_hh", i), 32'(alarm_hh), 32'(vecs[i].hh));
         check($sformatf("vec%0d_mm", i), 32'(alarm_mm), 32'(vecs[i].mm));
      end

      // edit wrap: 06 + 19 hours -> 01, 00 + 61 minutes -> 01
      alarm_on = 0; set_cur(12, 0, 30);
      reset = 0; step(); reset = 1;
      for (int i = 0; i < 19; i++) begin inc_hr_tick = 1; step(); end
      for (int i = 0; i < 61; i++) begin inc_min_tick = 1; step(); end
      check("wrap_hh", 32'(alarm_hh), 32'h01);
      check("wrap_mm", 32'(alarm_mm), 32'h01);

      // alarm 07:30, arm, trigger
      for (int i = 0; i < 6; i++)  begin inc_hr_tick = 1; step(); end
      for (int i = 0; i < 29; i++) begin inc_min_tick = 1; step(); end
      check("set_hh", 32'(alarm_hh), 32'h07);
      check("set_mm", 32'(alarm_mm), 32'h30);
      alarm_on = 1; step();
      expect_out("armed", 2'd1, 1'b0);
      set_cur(7, 30, 0); step();
      expect_out("trigger", 2'd2, 1'b1);

      // ring timeout after 4 sec_ticks (idle cycles in between do not count)
      set_cur(7, 30, 1);
      for (int i = 0; i < RING; i++) begin
         sec_tick = 1; step();
         if (i < RING - 1) expect_out("ringing", 2'd2, 1'b1);
         else              expect_out("timeout", 2'd1, 1'b0);
         step();
      end
      step();
      expect_out("no_retrig", 2'd1, 1'b0);

      // snooze then re-ring after 3 sec_ticks
      set_cur(7, 30, 0); step(); set_cur(7, 30, 1);
      expect_out("retrig", 2'd2, 1'b1);
      snooze_tick = 1; step();
      expect_out("snooze", 2'd3, 1'b0);
      for (int i = 0; i < SNZ; i++) begin
         sec_tick = 1; step();
         if (i < SNZ - 1) expect_out("snoozing", 2'd3, 1'b0);
         else             expect_out("rering", 2'd2, 1'b1);
      end

      // stop wins over snooze
      stop_tick = 1; snooze_tick = 1; step();
      expect_out("stop_wins", 2'd1, 1'b0);

      // disarm while in SNOOZE
      set_cur(7, 30, 0); step(); set_cur(7, 30, 1);
      snooze_tick = 1; step();
      expect_out("snooze2", 2'd3, 1'b0);
      alarm_on = 0; step();
      expect_out("disarm_snz", 2'd0, 1'b0);
      alarm_on = 1; step();

      // disarm beats stop while ringing
      set_cur(7, 30, 0); step(); set_cur(7, 30, 1);
      alarm_on = 0; stop_tick = 1; step();
      expect_out("disarm_ring", 2'd0, 1'b0);
      alarm_on = 1; step();

      // snooze limit: third snooze acts as stop when the limit is built
      set_cur(7, 30, 0); step(); set_cur(7, 30, 1);
      for (int k = 0; k < 2; k++) begin
         snooze_tick = 1; step();
         expect_out("lim_snooze", 2'd3, 1'b0);
         for (int i = 0; i < SNZ; i++) begin sec_tick = 1; step(); end
         expect_out("lim_rering", 2'd2, 1'b1);
      end
      snooze_tick = 1; step();
      if (LIMIT) expect_out("lim_third", 2'd1, 1'b0);
      else       expect_out("lim_third", 2'd3, 1'b0);

      // mid-ring reset: edits ignored while ringing, then all back to defaults
      stop_tick = 1; step();
      set_cur(7, 30, 0); step(); set_cur(7, 30, 1);
      inc_min_tick = 1; step();
      check("ring_noedit", 32'(alarm_mm), 32'h30);
      reset = 0; step(); reset = 1;
      expect_out("midring_rst", 2'd0, 1'b0);
      check("midring_hh", 32'(alarm_hh), 32'h06);
      check("midring_mm", 32'(alarm_mm), 32'h00);

      // editing onto the current time at second 00 creates a trigger
      step();
      expect_out("rearm", 2'd1, 1'b0);
      set_cur(6, 1, 0); inc_min_tick = 1; step();
      expect_out("edit_nomatch", 2'd1, 1'b0);
      step();
      expect_out("edit_trig", 2'd2, 1'b1);

      // randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         int r;
         reset        = ($urandom_range(0, 299) != 0);
         alarm_on     = ($urandom_range(0, 29) != 0);
         inc_hr_tick  = ($urandom_range(0, 19) == 0);
         inc_min_tick = ($urandom_range(0, 19) == 0);
         snooze_tick  = ($urandom_range(0, 19) == 0);
         stop_tick    = ($urandom_range(0, 29) == 0);
         sec_tick     = ($urandom_range(0, 2) == 0);
         r = int'($urandom_range(0, 9));
         if (r < 5) begin
            cur_h = m_h; cur_m = m_m;
            cur_s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 59));
         end else begin
            set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                    int'($urandom_range(0, 59)));
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
